// File: rtl/hlsi_vadd_rtl.sv
`default_nettype none
// ============================================================================
// Module : hlsi_vadd_rtl
// Brief  : ap_ctrl_hs vector adder, out[i] = in1[i] + in2[i] over BRAM ports.
// Rev    : 1.0  initial release
// ============================================================================
module hlsi_vadd_rtl #(
    parameter int unsigned N      = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] in1_Addr_A,
    output logic              in1_EN_A,
    output logic              in1_WEN_A,
    output logic [DATA_W-1:0] in1_Din_A,
    input  logic [DATA_W-1:0] in1_Dout_A,
    output logic [ADDR_W-1:0] in2_Addr_A,
    output logic              in2_EN_A,
    output logic              in2_WEN_A,
    output logic [DATA_W-1:0] in2_Din_A,
    input  logic [DATA_W-1:0] in2_Dout_A,
    output logic [ADDR_W-1:0] out_r_Addr_A,
    output logic              out_r_EN_A,
    output logic              out_r_WEN_A,
    output logic [DATA_W-1:0] out_r_Din_A,
    input  logic [DATA_W-1:0] out_r_Dout_A
);

    localparam int unsigned          C_CNT_W    = $clog2(N + 1);
    localparam logic [C_CNT_W-1:0]   C_LAST_IDX = C_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   rd_idx_q, rd_idx_d;
    logic [C_CNT_W-1:0]   wr_idx_q, wr_idx_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 done_q, done_d;
    logic                 idle_q, idle_d;
    logic [DATA_W-1:0]    w_sum;
    logic                 unused_out_dout;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            idle_q   <= idle_d;
        end
    end

    // Outputs are registered, so every value computed here is what the
    // ports will show during the cycle after the current one.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        rd_en_d  = 1'b0;
        // Read data returns one cycle after the read; write it back then.
        wr_en_d  = rd_en_q;
        wr_idx_d = rd_en_q ? rd_idx_q : wr_idx_q;
        done_d   = 1'b0;
        idle_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_d = 1'b1;
                if (ap_start) begin
                    state_d  = ST_RUN;
                    rd_en_d  = 1'b1;
                    rd_idx_d = '0;
                    idle_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (rd_idx_q == C_LAST_IDX) begin
                    state_d = ST_FLUSH;
                end else begin
                    rd_en_d  = 1'b1;
                    rd_idx_d = rd_idx_q + C_CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                if (ap_start) begin
                    state_d  = ST_RUN;
                    rd_en_d  = 1'b1;
                    rd_idx_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    idle_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = 1'b1;
            end
        endcase
    end

    // Write data rides straight off the read ports to keep the one-cycle
    // read-to-write turnaround; gated so it reads zero outside writes.
    assign w_sum           = in1_Dout_A + in2_Dout_A;
    assign out_r_Din_A     = wr_en_q ? w_sum : '0;
    assign unused_out_dout = ^out_r_Dout_A;

    assign ap_done      = done_q;
    assign ap_ready     = done_q;
    assign ap_idle      = idle_q;

    assign in1_Addr_A   = ADDR_W'(rd_idx_q);
    assign in1_EN_A     = rd_en_q;
    assign in1_WEN_A    = 1'b0;
    assign in1_Din_A    = '0;

    assign in2_Addr_A   = ADDR_W'(rd_idx_q);
    assign in2_EN_A     = rd_en_q;
    assign in2_WEN_A    = 1'b0;
    assign in2_Din_A    = '0;

    assign out_r_Addr_A = ADDR_W'(wr_idx_q);
    assign out_r_EN_A   = wr_en_q;
    assign out_r_WEN_A  = wr_en_q;

endmodule
`default_nettype wire
